// File: rtl/sample_mem_dma.sv
`timescale 1ns/1ps
// sample_mem_dma: Avalon-MM initiator moving 32-bit words between a
// valid/ready sample stream and the 8192x32 on-chip memory.
// Optional feature macro: SAMPLE_DMA_ABORT_EN (adds abort input and FLUSH state).
//
// Handshake: on both snk_* and src_* a beat transfers on every rising edge
// where valid and ready are both high; valid never depends on ready.
//
// Read path: the memory returns data one cycle after the issue, and that
// word is presented on src_* directly from avm_readdata while it is the only
// word held (bypass). It goes into the FIFO storage only if it is not
// consumed in that cycle. fifo_count + inflight therefore counts every word
// the block owns, and new reads are issued only while that sum < FIFO_DEPTH.
module sample_mem_dma #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 13,
  parameter int LEN_W      = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  input  logic [31:0]       snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  output logic [31:0]       src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  output logic              avm_clken,
`ifdef SAMPLE_DMA_ABORT_EN
  input  logic              abort,
`endif
  output logic [1:0]        dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
`ifdef SAMPLE_DMA_ABORT_EN
    , S_FLUSH = 2'd3
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_remain;
  logic              r_done;
  logic              r_inflight;
  logic [31:0]       r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_idx;
  logic [PW-1:0]     r_rd_idx;
  logic [CW-1:0]     r_count;

  logic              w_abort;
  logic              w_load;
  logic              w_done_set;
  logic              w_clear;
  logic              w_wr_beat;
  logic              w_issue;
  logic              w_src_valid;
  logic              w_pop;
  logic              w_pop_store;
  logic              w_push;
  logic [CW-1:0]     w_outstanding;
  logic [31:0]       w_head;

`ifdef SAMPLE_DMA_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_outstanding = r_count + CW'(r_inflight);
  assign w_wr_beat     = (r_state == S_WR) && snk_valid;
  assign w_issue       = (r_state == S_RD) && (r_remain != '0) &&
                         (w_outstanding < DEPTH_C) && !w_abort;
  assign w_src_valid   = (r_state == S_RD) && ((r_count != '0) || r_inflight);
  assign w_head        = (r_count != '0) ? r_fifo[r_rd_idx] : avm_readdata;
  assign w_pop         = w_src_valid && src_ready;
  assign w_pop_store   = w_pop && (r_count != '0);
  assign w_push        = r_inflight && !((r_count == '0) && w_pop);

  // Next-state and command decode; defaults first so nothing latches.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_done_set = 1'b0;
    w_clear    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          if (length == '0) w_done_set = 1'b1;
          else              w_next     = dir ? S_RD : S_WR;
        end
      end
      S_WR: begin
        if (w_abort || (w_wr_beat && (r_remain == LEN_W'(1)))) begin
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end
      end
      S_RD: begin
`ifdef SAMPLE_DMA_ABORT_EN
        if (w_abort) begin
          w_next = S_FLUSH;
        end else
`endif
        if ((r_remain == '0) && (w_outstanding == CW'(1)) && w_pop) begin
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end
      end
`ifdef SAMPLE_DMA_ABORT_EN
      S_FLUSH: begin
        w_next     = S_IDLE;
        w_done_set = 1'b1;
        w_clear    = 1'b1;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus the done pulse and the read-in-flight flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_done     <= w_done_set;
      r_inflight <= w_issue;
    end
  end

  // Address pointer and remaining-word counter; ptr wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_remain <= '0;
    end else if (w_load) begin
      r_ptr    <= base_addr;
      r_remain <= length;
    end else if (w_wr_beat || w_issue) begin
      r_ptr    <= r_ptr + ADDR_W'(1);
      r_remain <= r_remain - LEN_W'(1);
    end
  end

  // Read-return FIFO indices and occupancy; flush empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else if (w_clear) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)      r_wr_idx <= r_wr_idx + PW'(1);
      if (w_pop_store) r_rd_idx <= r_rd_idx + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop_store);
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_idx] <= avm_readdata;
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign snk_ready      = (r_state == S_WR);
  assign src_valid      = w_src_valid;
  assign src_data       = w_src_valid ? w_head : 32'h0;
  assign avm_address    = r_ptr;
  assign avm_chipselect = w_wr_beat || w_issue;
  assign avm_write      = w_wr_beat;
  assign avm_byteenable = 4'hF;
  assign avm_writedata  = snk_data;
  assign avm_clken      = 1'b1;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_sample_mem_dma.sv
`timescale 1ns/1ps
// Bench for sample_mem_dma: behavioural memory slave, word-level model of
// memory contents, expected bus/stream queues and cycle-timing checks.
module tb_sample_mem_dma;
  localparam int DEPTH     = 4;
  localparam int MEM_WORDS = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, dir;
  logic [12:0] base_addr;
  logic [13:0] length;
  logic        busy, done;
  logic [31:0] snk_data;
  logic        snk_valid, snk_ready;
  logic [31:0] src_data;
  logic        src_valid, src_ready;
  logic [12:0] avm_address;
  logic        avm_chipselect, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_clken;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sample_mem_dma #(.FIFO_DEPTH(DEPTH), .ADDR_W(13), .LEN_W(14)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_clken(avm_clken), .dbg_state(dbg_state)
  );

  // memory slave with fixed 1-cycle read latency
  logic [31:0] slave_mem [MEM_WORDS];
  logic [31:0] model_mem [MEM_WORDS];
  logic        mem_init;

  function automatic logic [31:0] init_word(int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) slave_mem[i] <= init_word(i);
    end else begin
      if (avm_chipselect && avm_write)  slave_mem[avm_address] <= avm_writedata;
      if (avm_chipselect && !avm_write) avm_readdata <= slave_mem[avm_address];
    end
  end

  // scoreboard
  logic [12:0] exp_wa_q[$];
  logic [31:0] exp_wd_q[$];
  logic [12:0] exp_ra_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] got_q[$];
  int outstanding = 0;
  int issue_cnt   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void flag(string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", nm, $time);
  endfunction

  // compare process: every bus cycle and stream beat against expectations
  always @(negedge clk) begin
    if (!reset) begin
      if (avm_chipselect) chk("byteenable", 32'(avm_byteenable), 32'hF);
      if (avm_chipselect && avm_write) begin
        if (exp_wa_q.size() == 0) flag("unexpected_write");
        else begin
          chk("wr_addr", 32'(avm_address), 32'(exp_wa_q.pop_front()));
          chk("wr_data", avm_writedata, exp_wd_q.pop_front());
        end
      end
      if (avm_chipselect && !avm_write) begin
        issue_cnt++;
        outstanding++;
        if (exp_ra_q.size() == 0) flag("unexpected_read");
        else chk("rd_addr", 32'(avm_address), 32'(exp_ra_q.pop_front()));
        n_checks++;
        if (outstanding > DEPTH) begin
          n_errors++;
          $display("FAIL rd_outstanding: got %0d allowed %0d", outstanding, DEPTH);
        end
      end
      if (src_valid && src_ready) begin
        outstanding--;
        got_q.push_back(src_data);
        if (exp_rd_q.size() == 0) flag("unexpected_src_word");
        else chk("src_data", src_data, exp_rd_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic start_cmd(input logic d, input logic [12:0] b, input int l, output int t);
    @(posedge clk); #1;
    start = 1'b1; dir = d; base_addr = b; length = 14'(l);
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_zero(input logic d, input logic [12:0] b);
    int t;
    start_cmd(d, b, 0, t);
    @(negedge clk);
    chk("len0_done", 32'(done), 1);
    chk("len0_busy", 32'(busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("len0_done_end", 32'(done), 0);
  endtask

  task automatic run_write(input logic [12:0] b, input int l, input bit fixed,
                           input bit gaps, input bit poke);
    logic [31:0] dq[$];
    logic [31:0] d;
    logic [12:0] a;
    int t, i, last_w, guard;
    for (int k = 0; k < l; k++) begin
      d = fixed ? (32'hA0 + 32'(k)) : $urandom();
      a = 13'((int'(b) + k) % MEM_WORDS);
      dq.push_back(d);
      exp_wa_q.push_back(a);
      exp_wd_q.push_back(d);
      model_mem[a] = d;
    end
    start_cmd(1'b0, b, l, t);
    i = 0; last_w = t; guard = 0;
    while (i < l && guard < 400) begin
      if (poke && guard == 0) begin
        start = 1'b1; dir = 1'b1; base_addr = 13'h0; length = 14'd5;
      end else start = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        snk_valid = 1'b0; snk_data = $urandom();
      end else begin
        snk_valid = 1'b1; snk_data = dq[i];
      end
      @(negedge clk);
      chk("wr_ready", 32'(snk_ready), 1);
      chk("wr_done_low", 32'(done), 0);
      if (snk_valid) begin last_w = cyc; i++; end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0; snk_valid = 1'b0; snk_data = 32'h0;
    if (i < l) flag("wr_timeout");
    @(negedge clk);
    chk("wr_done_cycle", 32'(cyc - last_w), 1);
    chk("wr_done", 32'(done), 1);
    chk("wr_busy_end", 32'(busy), 0);
    chk("wr_ready_end", 32'(snk_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_done_pulse", 32'(done), 0);
    chk("wr_idle", 32'(busy), 0);
  endtask

  // mode 0: ready held high, 1: random ready, 2: ready low for 10 cycles
  task automatic run_read(input logic [12:0] b, input int l, input int mode);
    logic [12:0] a;
    int t, pops, first_v, last_p, guard;
    for (int k = 0; k < l; k++) begin
      a = 13'((int'(b) + k) % MEM_WORDS);
      exp_ra_q.push_back(a);
      exp_rd_q.push_back(model_mem[a]);
    end
    issue_cnt = 0;
    start_cmd(1'b1, b, l, t);
    pops = 0; first_v = -1; last_p = -1; guard = 0;
    while (pops < l && guard < 400) begin
      case (mode)
        0:       src_ready = 1'b1;
        1:       src_ready = 1'($urandom_range(0, 1));
        default: src_ready = (cyc > t + 10);
      endcase
      @(negedge clk);
      if (mode == 2 && cyc == t + 10)
        chk("stall_issues", 32'(issue_cnt), 32'((l < DEPTH) ? l : DEPTH));
      chk("rd_done_low", 32'(done), 0);
      if (src_valid && first_v < 0) first_v = cyc;
      if (src_valid && src_ready) begin pops++; last_p = cyc; end
      @(posedge clk); #1;
      guard++;
    end
    src_ready = 1'b0;
    if (pops < l) flag("rd_timeout");
    @(negedge clk);
    chk("rd_done", 32'(done), 1);
    chk("rd_busy_end", 32'(busy), 0);
    chk("rd_valid_end", 32'(src_valid), 0);
    if (mode == 0) begin
      chk("rd_first_valid", 32'(first_v - t), 2);
      chk("rd_last_word", 32'(last_p - t), 32'(l + 1));
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_snk_ready"}, 32'(snk_ready), 0);
    chk({nm, "_src_valid"}, 32'(src_valid), 0);
    chk({nm, "_src_data"}, src_data, 0);
    chk({nm, "_cs"}, 32'(avm_chipselect), 0);
    chk({nm, "_wr"}, 32'(avm_write), 0);
    chk({nm, "_addr"}, 32'(avm_address), 0);
    chk({nm, "_be"}, 32'(avm_byteenable), 32'hF);
    chk({nm, "_clken"}, 32'(avm_clken), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, pops, guard;
    logic        rd_dir;
    logic [12:0] rb;
    int          rl;
    reset = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; length = '0;
    snk_data = '0; snk_valid = 1'b0; src_ready = 1'b0; mem_init = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = init_word(i);
    @(posedge clk); #1 mem_init = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;

    // continuous write of 0xA0..0xA3 to 0x10..0x13
    run_write(13'h0010, 4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk("wr_mem_pin", slave_mem[16 + i], 32'hA0 + 32'(i));

    // read back, ready held high
    got_q.delete();
    run_read(13'h0010, 4, 0);
    chk("rd_pin_count", 32'(got_q.size()), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk("rd_pin_word", got_q[i], 32'hA0 + 32'(i));

    // sink stalled for 10 cycles
    run_read(13'h0010, 8, 2);

    // address wrap
    run_write(13'h1FFE, 4, 1'b1, 1'b0, 1'b0);
    chk("wrap_pin0", slave_mem[13'h1FFE], 32'hA0);
    chk("wrap_pin1", slave_mem[13'h1FFF], 32'hA1);
    chk("wrap_pin2", slave_mem[0], 32'hA2);
    chk("wrap_pin3", slave_mem[1], 32'hA3);
    run_read(13'h1FFE, 4, 1);

    // zero length and start while busy
    run_zero(1'b0, 13'h0100);
    run_zero(1'b1, 13'h0100);
    run_write(13'h0300, 3, 1'b0, 1'b1, 1'b1);

    // reset in the middle of an 8-word read
    run_write(13'h0200, 8, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      exp_ra_q.push_back(13'h0200 + 13'(k));
      exp_rd_q.push_back(model_mem[13'h0200 + 13'(k)]);
    end
    start_cmd(1'b1, 13'h0200, 8, t);
    src_ready = 1'b1; pops = 0; guard = 0;
    while (pops < 3 && guard < 100) begin
      @(negedge clk);
      if (src_valid && src_ready) pops++;
      if (pops < 3) begin @(posedge clk); #1; end
      guard++;
    end
    if (pops < 3) flag("reset_test_timeout");
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    exp_ra_q.delete(); exp_rd_q.delete();
    outstanding = 0;
    src_ready = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    run_read(13'h0200, 2, 0);

    // randomized transactions
    for (int n = 0; n < 10; n++) begin
      rd_dir = 1'($urandom_range(0, 1));
      rb = (n % 3 == 0) ? 13'(13'h1FF0 + 13'($urandom_range(0, 15))) : 13'($urandom_range(0, 8191));
      rl = (n == 6) ? 0 : int'($urandom_range(1, 20));
      if (rl == 0)           run_zero(rd_dir, rb);
      else if (rd_dir == 0)  run_write(rb, rl, 1'b0, 1'b1, 1'b0);
      else                   run_read(rb, rl, 1);
    end

    chk("exp_wa_left", 32'(exp_wa_q.size()), 0);
    chk("exp_ra_left", 32'(exp_ra_q.size()), 0);
    chk("exp_rd_left", 32'(exp_rd_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
